// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one repeated-addition multiplier datapath among
// NREQ requesters. A round-robin arbiter picks a requester from IDLE, the
// FSM walks the datapath through LOAD, OPERATE and DONE, and the captured
// product is returned with the requester ID over a valid/ready channel.
module mult_rr_scheduler #(
   parameter int XLEN = 16,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XLEN-1:0] req_a,
   input  logic [NREQ*XLEN-1:0] req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [2*XLEN-1:0]    resp_product,
   output logic                 dp_ld_input,
   output logic [1:0]           dp_state,
   output logic                 dp_ready,
   output logic                 dp_done,
   output logic [XLEN-1:0]      dp_a,
   output logic [XLEN-1:0]      dp_b,
   input  logic                 dp_eqz,
   input  logic [2*XLEN-1:0]    dp_product,
   output logic                 busy,
   output logic [15:0]          op_count
);

   typedef enum logic [2:0] {IDLE, LOAD, OPERATE, DONE, RESP} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant_idx;
   logic           grant_vld;

   // First set bit strictly after ptr, wrapping modulo NREQ. Iterating from
   // the farthest candidate down lets the nearest one overwrite the result.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                            input logic [IDW-1:0]  ptr);
      logic [IDW:0] res;
      int           idx;
      res = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NREQ;
         if (vld[idx]) res = {1'b1, IDW'(idx)};
      end
      return res;
   endfunction

   // Round-robin candidate for this cycle.
   always_comb begin
      {grant_vld, grant_idx} = rr_pick(req_valid, rr_ptr);
   end

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic and the combinational grant.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (resetn && grant_vld) begin
               req_ready[grant_idx] = 1'b1;
               state_nxt            = LOAD;
            end
         end
         LOAD:    state_nxt = OPERATE;
         OPERATE: if (dp_eqz) state_nxt = DONE;
         DONE:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dp_ld_input = (state == LOAD);
   assign dp_state    = (state == OPERATE) ? 2'd1 :
                        (state == DONE)    ? 2'd2 : 2'd0;
   assign dp_ready    = (state == IDLE);
   assign dp_done     = (state == DONE);
   assign resp_valid  = (state == RESP);
   assign busy        = (state != IDLE);

   // Operand/ID capture on grant, product capture in DONE, completion count.
   // Operands are only written from IDLE, so they hold from LOAD through RESP.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dp_a         <= '0;
         dp_b         <= '0;
         resp_id      <= '0;
         resp_product <= '0;
         op_count     <= '0;
         rr_ptr       <= IDW'(NREQ - 1);
      end else begin
         if (state == IDLE && grant_vld) begin
            dp_a    <= req_a[int'(grant_idx)*XLEN +: XLEN];
            dp_b    <= req_b[int'(grant_idx)*XLEN +: XLEN];
            resp_id <= grant_idx;
            rr_ptr  <= grant_idx;
         end
         if (state == DONE) resp_product <= dp_product;
         if (state == RESP && resp_ready) op_count <= op_count + 16'd1;
      end
   end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one repeated-addition multiplier datapath among NREQ requesters.
- Arbitrates requests round-robin, then sequences the datapath through load, operate and done.
- Captures the product and returns it with the requester's ID over a valid/ready response channel.
- Sits between the client-side request ports and the datapath's ld_input/state/ready/done/eqz/product pins.

Parameters:
XLEN, 16, operand width; product is 2*XLEN
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), requester ID width (derived)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
req_valid  input  NREQ  per-requester operation request
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_a  input  NREQ*XLEN  operand A, requester i at [i*XLEN +: XLEN]
req_b  input  NREQ*XLEN  operand B (iteration count), same packing
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_id  output  IDW  requester that owns the result
resp_product  output  2*XLEN  A*B (truncation-free)
dp_ld_input  output  1  datapath operand load strobe
dp_state  output  2  datapath state: 0=READY, 1=OPERATE, 2=DONE
dp_ready  output  1  high while scheduler is idle
dp_done  output  1  high in the DONE cycle
dp_a  output  XLEN  operand A to datapath
dp_b  output  XLEN  operand B to datapath
dp_eqz  input  1  datapath B-counter is zero
dp_product  input  2*XLEN  datapath product, valid only while dp_state==2
busy  output  1  operation in flight (any state except IDLE)
op_count  output  16  completed responses, wraps 0xFFFF->0

Behaviour:
- FSM states: IDLE, LOAD, OPERATE, DONE, RESP.
- Reset: resetn sampled at posedge clk; it overrides everything, including mid-operation.
  - Reset values: state=IDLE; req_ready=0; resp_valid=0; resp_id=0; resp_product=0; dp_ld_input=0; dp_state=0; dp_a=0; dp_b=0; op_count=0; rr pointer=NREQ-1 (so requester 0 has first priority).
  - An in-flight operation is dropped with no response.
- IDLE:
  - dp_state=0, dp_ready=1.
  - If any req_valid is set, the grant g is the first set bit searching from pointer+1 upward, modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; no other bit is set.
  - On that edge: latch req_a[g] and req_b[g] into dp_a/dp_b, latch g into resp_id, set pointer=g, go to LOAD.
- LOAD (1 cycle): dp_ld_input=1, dp_state=0; next OPERATE.
- OPERATE: dp_state=1.
  - Stay while dp_eqz=0; go to DONE on the edge where dp_eqz=1.
  - Occupies exactly B+1 cycles; B=0 gives 1 cycle.
- DONE (1 cycle): dp_state=2, dp_done=1; register resp_product<=dp_product; next RESP.
- RESP: resp_valid=1 and held, with resp_id and resp_product stable, until resp_ready=1.
  - On the handshake edge: op_count+1, go to IDLE.
  - resp_ready=1 on the first RESP cycle completes in that cycle.
- Operand hold: dp_a and dp_b stay stable from the LOAD cycle through RESP.
- Arbitration timing:
  - req_ready is 0 in every state except IDLE, so new requests are accepted only from IDLE.
  - The cycle after a response handshake is IDLE and may accept a request (no bubble beyond that).
  - The pointer updates only on acceptance; requests that drop valid before grant are not remembered.
- Latency: resp_valid rises B+3 cycles after the request handshake edge.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,..,NREQ-1,0.
- Arithmetic: resp_product is the datapath result, unmodified; the scheduler performs no arithmetic.
- Counter widths: op_count is 16-bit modular.

Test Plan:
- Reset, then single req0 with a=7, b=5, resp_ready=1: req_ready[0] for 1 cycle, dp_ld_input 1 cycle, dp_state=1 for 6 cycles; resp_valid 8 cycles after accept with product 35, id 0, op_count=1.
- All NREQ=4 requesters hold valid with a=i+1, b=2: responses arrive in id order 0,1,2,3,0 with products 2,4,6,8,2; never two req_ready bits high.
- b=0, a=0xFFFF: OPERATE lasts 1 cycle, product 0; then a=0xFFFF, b=0xFFFF: product 0xFFFE0001, no truncation.
- Back-pressure: resp_ready=0 for 10 cycles in RESP: resp_valid/id/product stable, req_ready=0 for all, op_count unchanged until handshake.
- resetn=0 while in OPERATE with b=100: next cycle IDLE, all outputs at reset values, no response issued; pointer restarts so req0 wins over req3 when both are pending.
